// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the multicycle ALU: ALU control codes,
//            FSM state encoding and the iteration-counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control codes as produced by the ALU controller.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_MULT = 3'b101;
    localparam logic [2:0] ALU_DIV  = 3'b110;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/iter_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : iter_muldiv
// Purpose  : Iterative unsigned multiply (shift-add) and divide (restoring),
//            one step per enabled clock, WIDTH steps per operation.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            load           - start a new operation (captures op, a, b)
//            op             - 0 = MULT, 1 = DIV (sampled with load)
//            a, b           - operands (MULT: a*b, DIV: a/b)
//            step_en        - perform one iteration step this edge
//            lo, hi         - post-step value of the working registers;
//                             on the last step these are the final results
//                             (MULT: product low/high, DIV: quotient/rem)
//            last           - the next step is the final one
// Revision : 1.0 - initial release
// ============================================================================
module iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step_en,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             last
);

    localparam int CNT_W = cnt_width(WIDTH);

    // r_hi: product high / partial remainder
    // r_lo: multiplier shifting into product low / dividend shifting into quotient
    // r_opnd: multiplicand / divisor
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic             r_is_div;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    always_comb begin
        w_sum     = '0;
        w_shifted = '0;
        w_diff    = '0;
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        if (r_is_div) begin
            // Bring the next dividend bit into the remainder, try subtracting.
            w_shifted = {r_hi, r_lo[WIDTH-1]};
            w_diff    = w_shifted - {1'b0, r_opnd};
            if (w_diff[WIDTH]) begin
                // Negative: restore, quotient bit 0.
                w_hi_next = w_shifted[WIDTH-1:0];
                w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
            end else begin
                w_hi_next = w_diff[WIDTH-1:0];
                w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Add multiplicand if the current multiplier LSB is set, then
            // shift the {hi, lo} pair right by one, carry included.
            w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
            w_hi_next = w_sum[WIDTH:1];
            w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else if (load) begin
            r_hi     <= '0;
            r_lo     <= op ? a : b;
            r_opnd   <= op ? b : a;
            r_is_div <= op;
            r_cnt    <= CNT_W'(WIDTH);
        end else if (step_en && (r_cnt != '0)) begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign lo   = w_lo_next;
    assign hi   = w_hi_next;
    assign last = (r_cnt == CNT_W'(1));

endmodule : iter_muldiv
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_alu
// Purpose  : Execute-stage ALU. ADD/SUB/AND/OR/SLT finish in one cycle;
//            MULT/DIV iterate over WIDTH cycles behind start/busy/done.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            start          - operation request, sampled only in IDLE
//            alu_control    - 3-bit operation code (111 behaves as ADD)
//            a, b           - operands, captured on the accepted start
//            result         - low result word / quotient
//            result_hi      - product high / remainder / 0
//            zero           - registered (result == 0)
//            busy           - MULT/DIV iteration in progress
//            done           - one-cycle completion pulse
//            div_by_zero    - DIV attempted with b == 0
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    alu_state_t r_state;
    alu_state_t w_state_next;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zero;
    logic             r_div_by_zero;

    logic             w_accept;
    logic             w_is_mult;
    logic             w_is_div;
    logic             w_b_zero;
    logic             w_iter_load;
    logic             w_step_en;
    logic             w_finish_iter;
    logic             w_slt;
    logic [WIDTH-1:0] w_single;

    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;
    logic             w_md_last;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_is_mult = (alu_control == ALU_MULT);
    assign w_is_div  = (alu_control == ALU_DIV);
    assign w_b_zero  = (b == '0);
    assign w_slt     = ($signed(a) < $signed(b));

    // Single-cycle datapath; codes without a dedicated case fall to ADD.
    always_comb begin
        w_single = a + b;
        case (alu_control)
            ALU_SUB: w_single = a - b;
            ALU_AND: w_single = a & b;
            ALU_OR:  w_single = a | b;
            ALU_SLT: w_single = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_single = a + b;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        w_state_next  = r_state;
        w_iter_load   = 1'b0;
        w_step_en     = 1'b0;
        w_finish_iter = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // DIV by zero short-circuits to DONE without iterating.
                    if (w_is_mult || (w_is_div && !w_b_zero)) begin
                        w_iter_load  = 1'b1;
                        w_state_next = ST_ITER;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_ITER: begin
                w_step_en = 1'b1;
                if (w_md_last) begin
                    w_finish_iter = 1'b1;
                    w_state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter_muldiv (
        .clk     (clk),
        .reset   (reset),
        .load    (w_iter_load),
        .op      (w_is_div),
        .a       (a),
        .b       (b),
        .step_en (w_step_en),
        .lo      (w_md_lo),
        .hi      (w_md_hi),
        .last    (w_md_last)
    );

    // Output registers: loaded on single-cycle/div-by-zero acceptance or on
    // the final iteration step; otherwise they hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result      <= '0;
            r_result_hi   <= '0;
            r_zero        <= 1'b1;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            r_div_by_zero <= 1'b0;
            if (w_is_div && w_b_zero) begin
                r_result      <= '1;
                r_result_hi   <= a;
                r_zero        <= 1'b0;
                r_div_by_zero <= 1'b1;
            end else if (!(w_is_mult || w_is_div)) begin
                r_result    <= w_single;
                r_result_hi <= '0;
                r_zero      <= (w_single == '0);
            end
        end else if (w_finish_iter) begin
            r_result    <= w_md_lo;
            r_result_hi <= w_md_hi;
            r_zero      <= (w_md_lo == '0);
        end
    end

    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign zero        = r_zero;
    assign div_by_zero = r_div_by_zero;
    assign busy        = (r_state == ST_ITER);
    assign done        = (r_state == ST_DONE);

endmodule : multicycle_alu
`default_nettype wire
